// File: rtl/reflet_ram_sched.sv
// -----------------------------------------------------------------------------
// reflet_ram_sched
// Shares one synchronous RAM (1 write port, 1 registered read port with a
// 1-cycle read latency) between a host requester A (read/write) and a display
// scan-out requester B (read-only). A and B are arbitrated round-robin. A clear
// sequencer can fill the whole RAM with a constant.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   enable                0 freezes everything: no grants, no RAM accesses
//   a_req/a_we/a_addr/a_wdata -> a_ack      host request, accepted this cycle
//   a_rvalid/a_rdata                        host read result, 1 cycle after ack
//   b_req/b_addr -> b_ack                   display read request
//   b_rvalid/b_rdata                        display read result
//   clr_start/clr_value                     start a fill with clr_value
//   clr_busy/clr_done                       fill in progress / finished pulse
//   ram_*                                   RAM-side interface
// -----------------------------------------------------------------------------
module reflet_ram_sched #(
    parameter int addrSize = 7,
    parameter int size     = 128,
    parameter int depth    = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                a_req,
    input  logic                a_we,
    input  logic [addrSize-1:0] a_addr,
    input  logic [depth-1:0]    a_wdata,
    output logic                a_ack,
    output logic                a_rvalid,
    output logic [depth-1:0]    a_rdata,
    input  logic                b_req,
    input  logic [addrSize-1:0] b_addr,
    output logic                b_ack,
    output logic                b_rvalid,
    output logic [depth-1:0]    b_rdata,
    input  logic                clr_start,
    input  logic [depth-1:0]    clr_value,
    output logic                clr_busy,
    output logic                clr_done,
    output logic                ram_enable,
    output logic [addrSize-1:0] ram_addr_read,
    output logic [addrSize-1:0] ram_addr_write,
    output logic [depth-1:0]    ram_data_in,
    output logic                ram_write_en,
    input  logic [depth-1:0]    ram_data_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        CLEAR = 2'b01,
        DONE  = 2'b10
    } state_t;

    // cnt is one bit wider than the address so a full 2^addrSize fill ends cleanly
    localparam logic [addrSize:0] last_c = (addrSize + 1)'(size - 1);

    state_t                state_r;
    logic [addrSize:0]     cnt_r;
    logic [depth-1:0]      fill_r;
    logic                  clr_busy_r;
    logic                  clr_done_r;
    logic                  ptr_r;       // 0: A wins a tie, 1: B wins a tie
    logic                  a_rvalid_r;
    logic                  b_rvalid_r;
    logic                  rd_oor_r;    // pending read result is out of range
    logic [addrSize-1:0]   rd_addr_r;   // last read address presented to the RAM

    logic                  arb_ok_s;
    logic                  grant_a_s;
    logic                  grant_b_s;
    logic                  a_rd_s;
    logic                  a_wr_s;
    logic                  clear_wr_s;
    logic                  a_in_range_s;
    logic                  b_in_range_s;

    // Zero-extend to 32 bits so the bound check stays meaningful for any size
    function automatic logic in_range(input logic [addrSize-1:0] addr);
        in_range = ({{(32 - addrSize){1'b0}}, addr} < 32'(size));
    endfunction

    assign a_in_range_s = in_range(a_addr);
    assign b_in_range_s = in_range(b_addr);

    // Round-robin arbitration: only while idle, enabled and no clear is starting
    always_comb begin
        arb_ok_s  = 1'b0;
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
        if (!reset && enable && (state_r == IDLE) && !clr_start) begin
            arb_ok_s = 1'b1;
        end else begin
            arb_ok_s = 1'b0;
        end
        if (arb_ok_s) begin
            if (a_req && b_req) begin
                grant_a_s = ~ptr_r;
                grant_b_s = ptr_r;
            end else begin
                grant_a_s = a_req;
                grant_b_s = b_req;
            end
        end else begin
            grant_a_s = 1'b0;
            grant_b_s = 1'b0;
        end
    end

    assign a_ack      = grant_a_s;
    assign b_ack      = grant_b_s;
    assign a_rd_s     = grant_a_s & ~a_we;
    // out-of-range host writes are acknowledged but never reach the RAM
    assign a_wr_s     = grant_a_s & a_we & a_in_range_s;
    assign clear_wr_s = ~reset & enable & (state_r == CLEAR);
    // held low during reset so no access happens while state is being cleared
    assign ram_enable = enable & ~reset;

    // RAM write port: clear sequencer or granted host write
    always_comb begin
        ram_write_en   = 1'b0;
        ram_addr_write = {addrSize{1'b0}};
        ram_data_in    = {depth{1'b0}};
        if (clear_wr_s) begin
            ram_write_en   = 1'b1;
            ram_addr_write = cnt_r[addrSize-1:0];
            ram_data_in    = fill_r;
        end else if (a_wr_s) begin
            ram_write_en   = 1'b1;
            ram_addr_write = a_addr;
            ram_data_in    = a_wdata;
        end else begin
            ram_write_en   = 1'b0;
            ram_addr_write = {addrSize{1'b0}};
            ram_data_in    = {depth{1'b0}};
        end
    end

    // RAM read address: granted read, otherwise the last one (keeps RAM output stable)
    always_comb begin
        ram_addr_read = rd_addr_r;
        if (reset) begin
            ram_addr_read = {addrSize{1'b0}};
        end else if (a_rd_s) begin
            ram_addr_read = a_addr;
        end else if (grant_b_s) begin
            ram_addr_read = b_addr;
        end else begin
            ram_addr_read = rd_addr_r;
        end
    end

    // Read data return: RAM output for in-range reads, zero otherwise
    always_comb begin
        a_rdata = {depth{1'b0}};
        b_rdata = {depth{1'b0}};
        if (a_rvalid_r && !rd_oor_r) begin
            a_rdata = ram_data_out;
        end else begin
            a_rdata = {depth{1'b0}};
        end
        if (b_rvalid_r && !rd_oor_r) begin
            b_rdata = ram_data_out;
        end else begin
            b_rdata = {depth{1'b0}};
        end
    end

    assign a_rvalid = a_rvalid_r;
    assign b_rvalid = b_rvalid_r;
    assign clr_busy = clr_busy_r;
    assign clr_done = clr_done_r;

    // Read-return tags, held read address and round-robin pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            a_rvalid_r <= 1'b0;
            b_rvalid_r <= 1'b0;
            rd_oor_r   <= 1'b0;
            rd_addr_r  <= {addrSize{1'b0}};
            ptr_r      <= 1'b0;
        end else begin
            a_rvalid_r <= a_rd_s;
            b_rvalid_r <= grant_b_s;
            if (a_rd_s) begin
                rd_oor_r  <= ~a_in_range_s;
                rd_addr_r <= a_addr;
            end else if (grant_b_s) begin
                rd_oor_r  <= ~b_in_range_s;
                rd_addr_r <= b_addr;
            end else begin
                rd_oor_r  <= 1'b0;
                rd_addr_r <= rd_addr_r;
            end
            if (grant_a_s) begin
                ptr_r <= 1'b1;
            end else if (grant_b_s) begin
                ptr_r <= 1'b0;
            end else begin
                ptr_r <= ptr_r;
            end
        end
    end

    // Clear sequencer FSM; every transition waits for enable
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            cnt_r      <= {(addrSize + 1){1'b0}};
            fill_r     <= {depth{1'b0}};
            clr_busy_r <= 1'b0;
            clr_done_r <= 1'b0;
        end else if (enable) begin
            case (state_r)
                IDLE: begin
                    clr_done_r <= 1'b0;
                    if (clr_start) begin
                        state_r    <= CLEAR;
                        cnt_r      <= {(addrSize + 1){1'b0}};
                        fill_r     <= clr_value;
                        clr_busy_r <= 1'b1;
                    end else begin
                        clr_busy_r <= 1'b0;
                    end
                end
                CLEAR: begin
                    cnt_r <= cnt_r + {{addrSize{1'b0}}, 1'b1};
                    if (cnt_r == last_c) begin
                        state_r    <= DONE;
                        clr_busy_r <= 1'b0;
                        clr_done_r <= 1'b1;
                    end else begin
                        clr_busy_r <= 1'b1;
                        clr_done_r <= 1'b0;
                    end
                end
                DONE: begin
                    state_r    <= IDLE;
                    clr_busy_r <= 1'b0;
                    clr_done_r <= 1'b0;
                end
                default: begin
                    state_r    <= IDLE;
                    clr_busy_r <= 1'b0;
                    clr_done_r <= 1'b0;
                end
            endcase
        end else begin
            state_r    <= state_r;
            clr_busy_r <= clr_busy_r;
            clr_done_r <= clr_done_r;
        end
    end

endmodule

// File: tb/tb_reflet_ram_sched.sv
module tb_reflet_ram_sched;
    localparam int SIZE = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance (size 128)
    logic       reset, enable, a_req, a_we, b_req, clr_start;
    logic [6:0] a_addr, b_addr;
    logic [7:0] a_wdata, clr_value;
    logic       a_ack, a_rvalid, b_ack, b_rvalid, clr_busy, clr_done;
    logic       ram_enable, ram_write_en;
    logic [7:0] a_rdata, b_rdata, ram_data_in, ram_data_out;
    logic [6:0] ram_addr_read, ram_addr_write;

    // second instance (size 100, RAM output tied to 8'hFF)
    logic       s_a_req, s_a_we, s_b_req, s_clr_start;
    logic [6:0] s_a_addr, s_b_addr;
    logic [7:0] s_a_wdata;
    logic       s_a_ack, s_a_rvalid, s_b_ack, s_b_rvalid, s_clr_busy, s_clr_done;
    logic       s_ram_enable, s_ram_write_en;
    logic [7:0] s_a_rdata, s_b_rdata, s_ram_data_in;
    logic [6:0] s_ram_addr_read, s_ram_addr_write;
    logic       s_enable = 1'b1;
    logic [7:0] s_clr_value = 8'h11;
    logic [7:0] s_ram_data_out = 8'hFF;

    int checks = 0;
    int errors = 0;

    // reference model state
    int         cidx = -1;        // -1 idle, 0..SIZE-1 clearing word cidx, SIZE done cycle
    logic [7:0] fill_m = 8'h00;
    bit         turn_a = 1'b1;
    bit         pa = 1'b0, pb = 1'b0;
    logic [7:0] pa_d = 8'h00, pb_d = 8'h00;
    logic [6:0] held_m = 7'd0;
    bit         ga = 1'b0, gb = 1'b0;
    logic [7:0] ref_mem [0:127] = '{default: 8'h00};

    // behavioural RAM attached to the main instance
    logic [7:0] mem [0:127] = '{default: 8'h00};
    always @(posedge clk) begin
        if (ram_enable) begin
            if (ram_write_en) mem[ram_addr_write] <= ram_data_in;
            ram_data_out <= mem[ram_addr_read];
        end
    end

    reflet_ram_sched dut (
        .clk(clk), .reset(reset), .enable(enable),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_addr(b_addr), .b_ack(b_ack), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .clr_start(clr_start), .clr_value(clr_value), .clr_busy(clr_busy), .clr_done(clr_done),
        .ram_enable(ram_enable), .ram_addr_read(ram_addr_read), .ram_addr_write(ram_addr_write),
        .ram_data_in(ram_data_in), .ram_write_en(ram_write_en), .ram_data_out(ram_data_out)
    );

    reflet_ram_sched #(.addrSize(7), .size(100), .depth(8)) dut100 (
        .clk(clk), .reset(reset), .enable(s_enable),
        .a_req(s_a_req), .a_we(s_a_we), .a_addr(s_a_addr), .a_wdata(s_a_wdata),
        .a_ack(s_a_ack), .a_rvalid(s_a_rvalid), .a_rdata(s_a_rdata),
        .b_req(s_b_req), .b_addr(s_b_addr), .b_ack(s_b_ack), .b_rvalid(s_b_rvalid), .b_rdata(s_b_rdata),
        .clr_start(s_clr_start), .clr_value(s_clr_value), .clr_busy(s_clr_busy), .clr_done(s_clr_done),
        .ram_enable(s_ram_enable), .ram_addr_read(s_ram_addr_read), .ram_addr_write(s_ram_addr_write),
        .ram_data_in(s_ram_data_in), .ram_write_en(s_ram_write_en), .ram_data_out(s_ram_data_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Mid-cycle: predict this cycle's grants and compare every output with the model
    task automatic check_cycle();
        bit clearing, exp_we;
        logic [6:0] exp_ra;
        @(negedge clk);
        ga = 1'b0;
        gb = 1'b0;
        if (!reset && enable && cidx < 0 && !clr_start) begin
            if (a_req && (!b_req || turn_a)) ga = 1'b1;
            else if (b_req) gb = 1'b1;
        end
        clearing = (cidx >= 0 && cidx < SIZE);
        exp_we = (!reset && enable && clearing) || (ga && a_we && int'(a_addr) < SIZE);
        chk("a_ack", 32'(a_ack), 32'(ga));
        chk("b_ack", 32'(b_ack), 32'(gb));
        chk("ram_enable", 32'(ram_enable), 32'(enable && !reset));
        chk("ram_write_en", 32'(ram_write_en), 32'(exp_we));
        if (exp_we && clearing) begin
            chk("clr_waddr", 32'(ram_addr_write), 32'(cidx));
            chk("clr_wdata", 32'(ram_data_in), 32'(fill_m));
        end else if (exp_we) begin
            chk("a_waddr", 32'(ram_addr_write), 32'(a_addr));
            chk("a_wdata", 32'(ram_data_in), 32'(a_wdata));
        end
        exp_ra = reset ? 7'd0 : (ga && !a_we) ? a_addr : gb ? b_addr : held_m;
        chk("ram_addr_read", 32'(ram_addr_read), 32'(exp_ra));
        chk("a_rvalid", 32'(a_rvalid), 32'(pa));
        chk("a_rdata", 32'(a_rdata), 32'(pa ? pa_d : 8'h00));
        chk("b_rvalid", 32'(b_rvalid), 32'(pb));
        chk("b_rdata", 32'(b_rdata), 32'(pb ? pb_d : 8'h00));
        chk("clr_busy", 32'(clr_busy), 32'(clearing));
        chk("clr_done", 32'(clr_done), 32'(cidx == SIZE));
    endtask

    // Clock edge: advance the reference model
    task automatic advance();
        @(posedge clk);
        if (reset) begin
            cidx = -1; turn_a = 1'b1; pa = 1'b0; pb = 1'b0; held_m = 7'd0;
        end else begin
            pa   = ga && !a_we;
            pa_d = (int'(a_addr) < SIZE) ? ref_mem[a_addr] : 8'h00;
            pb   = gb;
            pb_d = (int'(b_addr) < SIZE) ? ref_mem[b_addr] : 8'h00;
            if (ga && !a_we) held_m = a_addr;
            else if (gb) held_m = b_addr;
            if (ga) turn_a = 1'b0;
            else if (gb) turn_a = 1'b1;
            if (ga && a_we && int'(a_addr) < SIZE) ref_mem[a_addr] = a_wdata;
            if (enable) begin
                if (cidx < 0) begin
                    if (clr_start) begin cidx = 0; fill_m = clr_value; end
                end else if (cidx < SIZE) begin
                    ref_mem[cidx] = fill_m;
                    cidx++;
                end else begin
                    cidx = -1;
                end
            end
        end
        #1;
    endtask

    task automatic tick();
        check_cycle();
        advance();
    endtask

    task automatic access_a(input bit we, input logic [6:0] addr, input logic [7:0] wd);
        bit got = 1'b0;
        a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd;
        for (int n = 0; n < 20 && !got; n++) begin
            check_cycle();
            got = ga;
            advance();
        end
        chk("access_grant", 32'(got), 32'd1);
        a_req = 1'b0;
    endtask

    task automatic read_a(input logic [6:0] addr, input logic [7:0] expv, input string tag);
        access_a(1'b0, addr, 8'h00);
        check_cycle();
        chk(tag, 32'(a_rdata), 32'(expv));
        advance();
    endtask

    initial begin
        bit seen;
        int busy_n;
        reset = 1'b1; enable = 1'b1; a_req = 1'b1; a_we = 1'b0; b_req = 1'b1;
        a_addr = 7'd0; b_addr = 7'd0; a_wdata = 8'h00; clr_start = 1'b0; clr_value = 8'h00;
        s_a_req = 1'b0; s_a_we = 1'b0; s_a_addr = 7'd0; s_a_wdata = 8'h00;
        s_b_req = 1'b0; s_b_addr = 7'd0; s_clr_start = 1'b0;

        // 1: reset with both requests raised
        tick();
        check_cycle();
        chk("rst_outs1", {a_ack, b_ack, a_rvalid, b_rvalid, clr_busy, clr_done, ram_enable,
                          ram_write_en, a_rdata, b_rdata}, 32'd0);
        chk("rst_outs2", {ram_addr_read, ram_addr_write, ram_data_in}, 32'd0);
        advance();
        reset = 1'b0; a_req = 1'b0; b_req = 1'b0;
        tick();

        // 2: write 5 then read it back
        a_req = 1'b1; a_we = 1'b1; a_addr = 7'd5; a_wdata = 8'hA5;
        check_cycle();
        chk("wr5_ack", 32'(a_ack), 32'd1);
        chk("wr5_we", 32'(ram_write_en), 32'd1);
        advance();
        read_a(7'd5, 8'hA5, "rd5_data");

        // 3: both requesters held for 6 cycles after a fresh reset
        reset = 1'b1; tick(); reset = 1'b0;
        a_req = 1'b1; a_we = 1'b0; b_req = 1'b1; a_addr = 7'd5; b_addr = 7'd9;
        for (int i = 0; i < 6; i++) begin
            check_cycle();
            chk("rr_a_ack", 32'(a_ack), 32'(i % 2 == 0));
            chk("rr_b_ack", 32'(b_ack), 32'(i % 2 == 1));
            if (i > 0) chk("rr_a_rvalid", 32'(a_rvalid), 32'(i % 2 == 1));
            advance();
            if (i % 2 == 0) a_addr = 7'($urandom_range(0, 127));
            else b_addr = 7'($urandom_range(0, 127));
        end
        a_req = 1'b0; b_req = 1'b0;
        check_cycle();
        chk("rr_last_b_rvalid", 32'(b_rvalid), 32'd1);
        advance();

        // 4: full clear with 8'h3C while both requesters wait
        a_req = 1'b1; b_req = 1'b1; clr_start = 1'b1; clr_value = 8'h3C;
        tick();
        clr_start = 1'b0;
        seen = 1'b0; busy_n = 0;
        for (int n = 0; n < 300 && !seen; n++) begin
            check_cycle();
            if (clr_done) seen = 1'b1;
            else if (clr_busy) busy_n++;
            chk("clr_stall", 32'({a_ack, b_ack}), 32'd0);
            advance();
        end
        a_req = 1'b0; b_req = 1'b0;
        chk("clr_busy_len", 32'(busy_n), 32'd128);
        chk("clr_done_seen", 32'(seen), 32'd1);
        read_a(7'd0, 8'h3C, "clr_rd0");
        read_a(7'd127, 8'h3C, "clr_rd127");

        // 5: reset during clear cycle 41 (words 0..39 written)
        access_a(1'b1, 7'd40, 8'h77);
        clr_start = 1'b1; clr_value = 8'hC3;
        tick();
        clr_start = 1'b0;
        repeat (40) tick();
        reset = 1'b1; tick(); reset = 1'b0;
        check_cycle();
        chk("abort_busy", 32'(clr_busy), 32'd0);
        chk("abort_done", 32'(clr_done), 32'd0);
        advance();
        read_a(7'd39, 8'hC3, "abort_rd39");
        read_a(7'd40, 8'h77, "abort_rd40");

        // 6: size=100 instance, out-of-range accesses and clear length
        s_a_req = 1'b1; s_a_we = 1'b0; s_a_addr = 7'd120;
        check_cycle(); chk("oor_rd_ack", 32'(s_a_ack), 32'd1); advance();
        s_a_req = 1'b0;
        check_cycle(); chk("oor_rd_valid", 32'({s_a_rvalid, s_a_rdata}), 32'h100); advance();
        s_a_req = 1'b1; s_a_we = 1'b1; s_a_addr = 7'd120; s_a_wdata = 8'h5A;
        check_cycle(); chk("oor_wr", 32'({s_a_ack, s_ram_write_en}), 32'b10); advance();
        s_a_addr = 7'd99;
        check_cycle(); chk("inr_wr", 32'({s_a_ack, s_ram_write_en}), 32'b11); advance();
        s_a_req = 1'b0; s_b_req = 1'b1; s_b_addr = 7'd100;
        check_cycle(); chk("oor_b_ack", 32'(s_b_ack), 32'd1); advance();
        s_b_addr = 7'd99;
        check_cycle(); chk("oor_b_data", 32'({s_b_rvalid, s_b_rdata}), 32'h100); advance();
        s_b_req = 1'b0;
        check_cycle(); chk("inr_b_data", 32'({s_b_rvalid, s_b_rdata}), 32'h1FF); advance();
        s_clr_start = 1'b1; tick(); s_clr_start = 1'b0;
        seen = 1'b0; busy_n = 0;
        for (int n = 0; n < 300 && !seen; n++) begin
            check_cycle();
            if (s_clr_done) seen = 1'b1;
            else if (s_clr_busy) busy_n++;
            advance();
        end
        chk("s_clr_busy_len", 32'(busy_n), 32'd100);
        chk("s_clr_done_seen", 32'(seen), 32'd1);

        // randomized traffic against the model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!(a_req && !ga)) begin
                a_req   = ($urandom_range(0, 2) != 0);
                a_we    = 1'($urandom_range(0, 1));
                a_addr  = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127))
                                                      : 7'($urandom_range(0, 15));
                a_wdata = 8'($urandom);
            end
            if (!(b_req && !gb)) begin
                b_req  = ($urandom_range(0, 2) != 0);
                b_addr = 7'($urandom_range(0, 15));
            end
            enable    = ($urandom_range(0, 9) != 0);
            clr_start = ($urandom_range(0, 199) == 0);
            clr_value = 8'($urandom);
            reset     = ($urandom_range(0, 499) == 0);
            tick();
        end
        reset = 1'b0; enable = 1'b1; a_req = 1'b0; b_req = 1'b0; clr_start = 1'b0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
